stream_gen_mc: RTL and testbench
================================

STREAM_GEN_MC -- requirements
Module: stream_gen_mc

Interface
REQ-001 Parameter DATA_W, default 8, byte width of every stored word and of m_tdata.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 Parameter NUM_DEST, default 5, number of stream destinations (m1 m2 s1 s2 s3 in the system bench).
REQ-004 Derived constants: CNT_W = clog2(DEPTH+1); SEL_W = max(1, clog2(NUM_DEST)).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 din  in  DATA_W  word to load.
REQ-008 push  in  1  load din this cycle.
REQ-009 op_en  in  1  level; permits packet launch.
REQ-010 pkt_len  in  CNT_W  beats per packet; 0 = whole buffer content.
REQ-011 dest_sel  in  SEL_W  destination index for next packet.
REQ-012 replay  in  1  sampled at launch; 1 = each sent word rewritten at FIFO tail.
REQ-013 m_tdata  out  DATA_W  shared data to all destinations.
REQ-014 m_tvalid  out  NUM_DEST  one-hot valid; only latched destination bit may be 1.
REQ-015 m_tready  in  NUM_DEST  per-destination ready.
REQ-016 m_tlast  out  1  final beat of packet.
REQ-017 buff_count  out  CNT_W; empty  out  1; full  out  1.
REQ-018 busy  out  1  state != IDLE; drop  out  1  one-cycle pulse on rejected push; sel_err  out  1  one-cycle pulse on invalid dest_sel at launch.

Function
REQ-019 FIFO: push accepted iff !full and not (STREAM with replay latched); write at tail, buff_count+1 next cycle.
REQ-020 Rejected push: word discarded, drop=1 next cycle, no state change; push while full with simultaneous pop is still rejected.
REQ-021 No fall-through: word pushed in cycle N earliest launchable in cycle N+1.
REQ-022 States IDLE, STREAM only.
REQ-023 IDLE -> STREAM when op_en && !empty && dest_sel < NUM_DEST; latch dest, replay, len = (pkt_len==0 || pkt_len>buff_count) ? buff_count : pkt_len.
REQ-024 IDLE with op_en && !empty && dest_sel >= NUM_DEST: stay IDLE, sel_err pulse, repeats each cycle condition holds.
REQ-025 STREAM: m_tvalid[dest]=1, m_tdata=FIFO head, m_tlast=(beat==len-1); first beat one cycle after launch.
REQ-026 Beat transfers when m_tvalid[dest] && m_tready[dest]; other m_tready bits ignored.
REQ-027 m_tdata, m_tlast, m_tvalid stable while stalled (valid && !ready).
REQ-028 Transfer pops head (buff_count-1), unless replay latched: head rewritten at tail same cycle, buff_count unchanged.
REQ-029 Non-replay push during STREAM accepted and excluded from current len; push+pop same cycle leaves buff_count unchanged.
REQ-030 Transfer with m_tlast -> IDLE; next launch earliest following cycle (one bubble cycle minimum).
REQ-031 op_en deasserted mid-packet: packet completes, no truncation; pkt_len/dest_sel/replay changes mid-packet ignored.
REQ-032 Pointers wrap modulo DEPTH; full=(buff_count==DEPTH), empty=(buff_count==0).

Reset
REQ-033 rst=1: state IDLE, pointers 0, buff_count 0, empty 1, full 0, m_tvalid 0, m_tlast 0, m_tdata 0, busy 0, drop 0, sel_err 0, next cycle.
REQ-034 Reset mid-packet aborts packet, FIFO contents discarded; rst dominates push and op_en same cycle.

Structure
REQ-035 Shared package stream_gen_pkg holds state enum (IDLE, STREAM) and clog2-based width helper.
REQ-036 One sub-module sync_fifo (parametrised DATA_W, DEPTH; push/pop/count/full/empty, simultaneous push+pop); FSM, beat counter, demux in stream_gen_mc.

Verification
REQ-037 Push 11,22,33,44; pkt_len=0, dest_sel=0, op_en=1, m_tready=all 1 -> m_tvalid=5'b00001, beats 11,22,33,44, m_tlast on 44, empty=1 after.
REQ-038 Push 8 words (full=1), push 9th -> drop pulse, buff_count stays 8, 9th word never output.
REQ-039 Push AA,BB; replay=1, pkt_len=2, dest_sel=2, op_en held -> AA,BB,AA,BB repeated on m_tvalid bit 2, buff_count constant 2, bubble between packets.
REQ-040 dest_sel=3, m_tready[3] toggles 1,0,0,1; m_tready[0]=1 -> data/tlast stable during stall, no transfer counted from m_tready[0].
REQ-041 dest_sel=6 with NUM_DEST=5 -> sel_err pulses, m_tvalid 0, busy 0.
REQ-042 Assert rst after 2 of 4 beats -> m_tvalid 0, buff_count 0, busy 0 next cycle; relaunch after fresh push works.

Source files
------------

// File: rtl/stream_gen_pkg.sv
// rtl/stream_gen_pkg.sv - shared state type and width helpers for stream_gen_mc
//
// Purpose: holds the packet FSM state enum and the width helpers used by
// every file of the block, so that all of them derive the same widths.
// Ports: none (package).
package stream_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a destination index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_gen_mc_if.sv
// rtl/stream_gen_mc_if.sv - shared-data, per-destination-valid stream bundle
//
// Purpose: groups the outgoing stream of stream_gen_mc. tdata and tlast are
// shared by every destination; tvalid/tready carry one bit per destination.
// Signals:
//   tdata  [DATA_W]   beat data
//   tvalid [NUM_DEST] one-hot valid
//   tready [NUM_DEST] per-destination ready
//   tlast             final beat of the packet
// Modports: master (the generator), slave (the destinations).
interface stream_gen_mc_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 5
) ();

  logic [DATA_W-1:0]   tdata;
  logic [NUM_DEST-1:0] tvalid;
  logic [NUM_DEST-1:0] tready;
  logic                tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with simultaneous push and pop
//
// Purpose: storage behind stream_gen_mc. The head word is presented
// combinationally on rd_data; a write lands at the tail and becomes visible
// as count+1 on the next cycle, so there is no fall-through.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en, wr_data   write request and word
//   rd_en            pop the head word
//   rd_data          current head word
//   count            number of stored words (0..DEPTH)
//   full, empty      count == DEPTH, count == 0
module sync_fifo import stream_gen_pkg::*; #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 8,
  localparam int CNT_W  = cnt_width(DEPTH),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr, do_rd;

  always_comb begin
    // A write into a full FIFO is allowed only when the head leaves in the
    // same cycle; the caller uses this to rotate the head to the tail.
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/stream_gen_mc.sv
// rtl/stream_gen_mc.sv - buffered packet generator with one-of-N destinations
//
// Purpose: words pushed on din are buffered in a FIFO. When op_en is high
// and the buffer is not empty, a packet of pkt_len beats (0 or too large =
// everything buffered) is sent from the FIFO head to destination dest_sel.
// With replay latched, each sent word is written back at the tail instead
// of being consumed, so the buffer content is played out again and again.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   din, push          word to load and its strobe
//   op_en              level enable for packet launch
//   pkt_len            beats per packet, 0 = whole buffer
//   dest_sel           destination index for the next packet
//   replay             keep sent words in the buffer (sampled at launch)
//   m                  outgoing stream (master side)
//   buff_count         words held; empty / full flags
//   busy               a packet is in progress
//   drop               one-cycle pulse: a push was rejected
//   sel_err            one-cycle pulse: launch refused for a bad dest_sel
module stream_gen_mc import stream_gen_pkg::*; #(
  parameter int  DATA_W   = 8,
  parameter int  DEPTH    = 8,
  parameter int  NUM_DEST = 5,
  localparam int CNT_W    = cnt_width(DEPTH),
  localparam int SEL_W    = sel_width(NUM_DEST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              push,
  input  logic              op_en,
  input  logic [CNT_W-1:0]  pkt_len,
  input  logic [SEL_W-1:0]  dest_sel,
  input  logic              replay,
  stream_gen_mc_if.master   m,
  output logic [CNT_W-1:0]  buff_count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              drop,
  output logic              sel_err
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    dest_q, dest_d;
  logic                replay_q, replay_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                drop_q, drop_d;
  logic                sel_err_q, sel_err_d;

  logic [DATA_W-1:0]   head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic                fifo_wr;
  logic [DATA_W-1:0]   fifo_wr_data;
  logic [NUM_DEST-1:0] dest_mask;
  logic                dest_ok;
  logic                push_ok;
  logic                xfer;
  logic                last_beat;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (xfer),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dest_ok   = (int'(dest_sel) < NUM_DEST);
  assign dest_mask = NUM_DEST'(1) << dest_q;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    replay_d  = replay_q;
    len_d     = len_q;
    beat_d    = beat_q;
    sel_err_d = 1'b0;
    xfer      = 1'b0;
    last_beat = 1'b0;
    m.tvalid  = '0;
    m.tdata   = '0;
    m.tlast   = 1'b0;

    // During a replay packet the tail write port belongs to the rotation,
    // so external pushes are refused. A push into a full FIFO is refused
    // even if a pop happens in the same cycle.
    push_ok = push && !fifo_full && !((state_q == STREAM) && replay_q);
    drop_d  = push && !push_ok;

    case (state_q)
      IDLE: begin
        if (op_en && !fifo_empty) begin
          if (dest_ok) begin
            state_d  = STREAM;
            dest_d   = dest_sel;
            replay_d = replay;
            beat_d   = '0;
            // Length is fixed from the count before any same-cycle push.
            len_d    = ((pkt_len == '0) || (pkt_len > fifo_count)) ? fifo_count : pkt_len;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        last_beat = (beat_q == (len_q - CNT_W'(1)));
        m.tvalid  = dest_mask;
        m.tdata   = head;
        m.tlast   = last_beat;
        // Only the latched destination's ready bit can complete a beat.
        xfer      = |(dest_mask & m.tready);
        if (xfer) begin
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fifo_wr      = push_ok || (xfer && replay_q);
    fifo_wr_data = (xfer && replay_q) ? head : din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      replay_q  <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      drop_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      replay_q  <= replay_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      drop_q    <= drop_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign buff_count = fifo_count;
  assign empty      = fifo_empty;
  assign full       = fifo_full;
  assign busy       = (state_q == STREAM);
  assign drop       = drop_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_stream_gen_mc.sv
// tb/tb_stream_gen_mc.sv - self-checking bench for stream_gen_mc
module tb_stream_gen_mc;
  import stream_gen_pkg::*;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int NUM_DEST = 5;
  localparam int CNT_W    = cnt_width(DEPTH);
  localparam int SEL_W    = sel_width(NUM_DEST);

  logic                clk = 1'b0;
  logic                rst;
  logic [DATA_W-1:0]   din;
  logic                push;
  logic                op_en;
  logic [CNT_W-1:0]    pkt_len;
  logic [SEL_W-1:0]    dest_sel;
  logic                replay;
  logic [NUM_DEST-1:0] tready;
  logic [CNT_W-1:0]    buff_count;
  logic                empty, full, busy, drop, sel_err;

  stream_gen_mc_if #(.DATA_W(DATA_W), .NUM_DEST(NUM_DEST)) sif ();
  assign sif.tready = tready;

  stream_gen_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_DEST(NUM_DEST)) dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .op_en(op_en),
    .pkt_len(pkt_len), .dest_sel(dest_sel), .replay(replay), .m(sif),
    .buff_count(buff_count), .empty(empty), .full(full), .busy(busy),
    .drop(drop), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of words; a packet is a
  // destination, a replay flag, a length and the number of beats done.
  logic [DATA_W-1:0] mq[$];
  bit m_on = 0, m_rep = 0, m_drop = 0, m_sel = 0;
  int m_dest = 0, m_len = 0, m_beat = 0;

  task automatic model_update();
    bit xf, pok, launch;
    int sz;
    logic [DATA_W-1:0] w;
    if (rst) begin
      mq.delete();
      m_on = 0; m_drop = 0; m_sel = 0;
      return;
    end
    sz     = mq.size();
    xf     = m_on && tready[m_dest];
    pok    = push && (sz < DEPTH) && !(m_on && m_rep);
    m_drop = push && !pok;
    m_sel  = !m_on && op_en && (sz > 0) && (int'(dest_sel) >= NUM_DEST);
    launch = !m_on && op_en && (sz > 0) && (int'(dest_sel) < NUM_DEST);
    if (xf) begin
      w = mq.pop_front();
      if (m_rep) mq.push_back(w);
      m_beat++;
      if (m_beat == m_len) m_on = 0;
    end
    if (pok) mq.push_back(din);
    if (launch) begin
      m_on   = 1;
      m_dest = int'(dest_sel);
      m_rep  = replay;
      m_beat = 0;
      m_len  = ((pkt_len == 0) || (int'(pkt_len) > sz)) ? sz : int'(pkt_len);
    end
  endtask

  task automatic model_check();
    logic [31:0] ev, ed;
    ev = m_on ? (32'(1) << m_dest) : 32'(0);
    ed = m_on ? 32'(mq[0]) : 32'(0);
    chk("mdl_tvalid", 32'(sif.tvalid), ev);
    chk("mdl_tdata", 32'(sif.tdata), ed);
    chk("mdl_tlast", 32'(sif.tlast), 32'(m_on && (m_beat == m_len - 1)));
    chk("mdl_count", 32'(buff_count), 32'(mq.size()));
    chk("mdl_empty", 32'(empty), 32'(mq.size() == 0));
    chk("mdl_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("mdl_busy", 32'(busy), 32'(m_on));
    chk("mdl_drop", 32'(drop), 32'(m_drop));
    chk("mdl_sel_err", 32'(sel_err), 32'(m_sel));
  endtask

  // One clock: inputs were set after the previous edge; compare 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  task automatic idle_in();
    rst = 0; push = 0; din = '0; op_en = 0; pkt_len = '0;
    dest_sel = '0; replay = 0; tready = '1;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; step(); rst = 0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    push = 1; din = w; step(); push = 0;
  endtask

  typedef struct {
    int rst, push, din, op, len, dsel, rep, rdy;
    int e_valid, e_data, e_last, e_cnt, e_busy, e_drop, e_sel;
  } vec_t;

  function automatic vec_t mk(int r, int p, int d, int o, int l, int s, int rp, int rd,
                              int ev, int ed, int el, int ec, int eb, int edr, int es);
    vec_t v;
    v.rst = r; v.push = p; v.din = d; v.op = o; v.len = l; v.dsel = s; v.rep = rp; v.rdy = rd;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_cnt = ec;
    v.e_busy = eb; v.e_drop = edr; v.e_sel = es;
    return v;
  endfunction

  vec_t tbl[17];
  logic [DATA_W-1:0] got[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst = 1;

    //          rst push din   op len sel rep rdy   valid data  last cnt busy drop sel
    tbl[0]  = mk(1, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 'h11, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 'h22, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 2, 0, 0, 0);
    tbl[3]  = mk(0, 1, 'h33, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 3, 0, 0, 0);
    tbl[4]  = mk(0, 1, 'h44, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 4, 0, 0, 0);
    tbl[5]  = mk(0, 0, 'h00, 1, 0, 0, 0, 'h1f, 'h01, 'h11, 0, 4, 1, 0, 0);
    tbl[6]  = mk(0, 0, 'h00, 0, 3, 4, 1, 'h1f, 'h01, 'h22, 0, 3, 1, 0, 0);
    tbl[7]  = mk(0, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h01, 'h33, 0, 2, 1, 0, 0);
    tbl[8]  = mk(0, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h01, 'h44, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 'h55, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 'h00, 1, 0, 6, 0, 'h1f, 'h00, 'h00, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 'h00, 1, 0, 6, 0, 'h1f, 'h00, 'h00, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 1, 'h66, 0, 0, 6, 0, 'h1f, 'h00, 'h00, 0, 2, 0, 0, 0);
    tbl[14] = mk(0, 0, 'h00, 1, 9, 1, 0, 'h1f, 'h02, 'h55, 0, 2, 1, 0, 0);
    tbl[15] = mk(0, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h02, 'h66, 1, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 'h00, 0, 0, 0, 0, 'h1f, 'h00, 'h00, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst[0]; push = tbl[i].push[0]; din = DATA_W'(tbl[i].din);
      op_en = tbl[i].op[0]; pkt_len = CNT_W'(tbl[i].len); dest_sel = SEL_W'(tbl[i].dsel);
      replay = tbl[i].rep[0]; tready = NUM_DEST'(tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_tvalid", i), 32'(sif.tvalid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_tdata", i), 32'(sif.tdata), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_tlast", i), 32'(sif.tlast), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_count", i), 32'(buff_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_drop", i), 32'(drop), 32'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_sel_err", i), 32'(sel_err), 32'(tbl[i].e_sel));
    end
    chk("rst_empty_after_pkt", 32'(empty), 32'(1));

    // Fill to full, reject a ninth word, then stream all eight out.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DATA_W'(8'hA0 + i));
    chk("full_at_8", 32'(full), 32'(1));
    push_word(8'h99);
    chk("drop_on_full", 32'(drop), 32'(1));
    chk("count_stays_8", 32'(buff_count), 32'(8));
    step();
    chk("drop_one_cycle", 32'(drop), 32'(0));
    op_en = 1; pkt_len = '0; dest_sel = 1; tready = '1;
    step();
    op_en = 0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      push = (c == 0);
      din  = 8'h99;
      if (sif.tvalid[1]) got.push_back(sif.tdata);
      step();
      if (c == 0) chk("drop_full_with_pop", 32'(drop), 32'(1));
    end
    push = 0;
    chk("full_beats", 32'(got.size()), 32'(8));
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("full_beat%0d", i), 32'(got[i]), 32'(8'hA0 + i));

    // Replay: AA,BB repeated on destination 2 with a bubble between packets.
    do_reset();
    push_word(8'hAA);
    push_word(8'hBB);
    replay = 1; pkt_len = 2; dest_sel = 2; op_en = 1; tready = '1;
    begin
      logic [7:0] exp_d[9];
      logic [4:0] exp_v[9];
      exp_d = '{8'hAA, 8'hBB, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'hAA, 8'hBB, 8'h00};
      exp_v = '{5'h04, 5'h04, 5'h00, 5'h04, 5'h04, 5'h00, 5'h04, 5'h04, 5'h00};
      for (int i = 0; i < 9; i++) begin
        push = (i == 1);
        din  = 8'h77;
        step();
        chk($sformatf("rep%0d_tvalid", i), 32'(sif.tvalid), 32'(exp_v[i]));
        chk($sformatf("rep%0d_tdata", i), 32'(sif.tdata), 32'(exp_d[i]));
        chk($sformatf("rep%0d_count", i), 32'(buff_count), 32'(2));
        if (i == 1) chk("rep_push_dropped", 32'(drop), 32'(1));
      end
    end
    push = 0;

    // Stall on destination 3 while an unrelated ready bit stays high.
    do_reset();
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    dest_sel = 3; pkt_len = 2; op_en = 1; tready = 5'b00001;
    step();
    op_en = 0;
    chk("stall_first", 32'(sif.tdata), 32'(8'h31));
    chk("stall_first_v", 32'(sif.tvalid), 32'(5'b01000));
    begin
      logic [4:0] rdy[4];
      logic [7:0] ed[4];
      logic [3:0] ec[4];
      logic       el[4];
      logic [4:0] ev[4];
      rdy = '{5'b01001, 5'b00001, 5'b00001, 5'b01001};
      ed  = '{8'h32, 8'h32, 8'h32, 8'h00};
      el  = '{1'b1, 1'b1, 1'b1, 1'b0};
      ec  = '{4'd2, 4'd2, 4'd2, 4'd1};
      ev  = '{5'b01000, 5'b01000, 5'b01000, 5'b00000};
      for (int i = 0; i < 4; i++) begin
        tready = rdy[i];
        step();
        chk($sformatf("stall%0d_tdata", i), 32'(sif.tdata), 32'(ed[i]));
        chk($sformatf("stall%0d_tlast", i), 32'(sif.tlast), 32'(el[i]));
        chk($sformatf("stall%0d_count", i), 32'(buff_count), 32'(ec[i]));
        chk($sformatf("stall%0d_tvalid", i), 32'(sif.tvalid), 32'(ev[i]));
      end
    end

    // Reset mid-packet, then relaunch from a fresh word.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(DATA_W'(8'hC1 + i));
    dest_sel = 4; pkt_len = 0; op_en = 1; tready = '1;
    step();
    op_en = 0;
    step();
    step();
    chk("mid_tdata", 32'(sif.tdata), 32'(8'hC3));
    rst = 1; push = 1; din = 8'hEE; op_en = 1;
    step();
    rst = 0; op_en = 0;
    chk("rst_tvalid", 32'(sif.tvalid), 32'(0));
    chk("rst_count", 32'(buff_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_tlast", 32'(sif.tlast), 32'(0));
    push_word(8'h5A);
    op_en = 1; dest_sel = 4;
    step();
    op_en = 0;
    chk("relaunch_tvalid", 32'(sif.tvalid), 32'(5'b10000));
    chk("relaunch_tdata", 32'(sif.tdata), 32'(8'h5A));
    chk("relaunch_tlast", 32'(sif.tlast), 32'(1));
    step();
    chk("relaunch_done", 32'(busy), 32'(0));

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      push     = 1'($urandom_range(0, 1));
      din      = DATA_W'($urandom);
      op_en    = ($urandom_range(0, 9) < 7);
      pkt_len  = CNT_W'($urandom);
      dest_sel = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom) : SEL_W'($urandom_range(0, NUM_DEST - 1));
      replay   = ($urandom_range(0, 3) == 0);
      tready   = NUM_DEST'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
